// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI raster sequencer: FSM encoding, control-word
// levels and the default 640x480@60 timing set.
package dvi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  localparam int CNT_W = 10;

  localparam logic [1:0] CTRL_IDLE = 2'b00;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sync pin level for an asserted/deasserted pulse of the given polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/dvi_delay_line.sv
// Fixed-depth shift register that retimes the raster flags to the pixel data.
module dvi_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dvi_timing_sequencer.sv
// Raster counter and sequencing FSM for the DVI output; issues pixel requests
// and produces de/sync aligned to the pixel source latency.
//
// state    | meaning
// IDLE     | counters parked at (0,0), no requests
// RUN      | free-running raster
// DRAIN    | run disabled, finishing the current frame
module dvi_timing_sequencer
  import dvi_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   PIX_LAT  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic             o_req,
  output logic [CNT_W-1:0] o_sx,
  output logic [CNT_W-1:0] o_sy,
  output logic             o_de,
  output logic [1:0]       o_ctrl0,
  output logic [1:0]       o_ctrl1,
  output logic [1:0]       o_ctrl2,
  output logic             o_frame,
  output logic             o_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("dvi_timing_sequencer: raster totals exceed 10-bit counters");
  end
  if (PIX_LAT < 1 || PIX_LAT > 8) begin : g_lat_check
    $error("dvi_timing_sequencer: PIX_LAT outside 1..8");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   H_ACT  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_ACT  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   HS_ON  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]   HS_OFF = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   VS_ON  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   VS_OFF = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] h_q, v_q;
  logic [CNT_W:0]   h_x, v_x;
  logic             at_end, running;
  logic             act_c, hs_c, vs_c, frame_c;
  logic             hs_r, vs_r;
  logic             de_d, hs_d, vs_d;

  assign h_x     = {1'b0, h_q};
  assign v_x     = {1'b0, v_q};
  assign at_end  = (h_q == H_LAST) && (v_q == V_LAST);
  assign running = (state_q != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_en) state_d = ST_RUN;
      ST_RUN:   if (!i_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (i_en)        state_d = ST_RUN;
        else if (at_end) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters only move outside IDLE, so the first RUN cycle always sees (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!running) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end else begin
      h_q <= h_q + 10'd1;
    end
  end

  assign act_c   = running && (h_x < H_ACT) && (v_x < V_ACT);
  assign hs_c    = running && (h_x >= HS_ON) && (h_x < HS_OFF);
  assign vs_c    = running && (v_x >= VS_ON) && (v_x < VS_OFF);
  assign frame_c = running && (h_q == '0) && (v_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_req   <= 1'b0;
      o_sx    <= '0;
      o_sy    <= '0;
      o_frame <= 1'b0;
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
    end else begin
      o_req   <= act_c;
      o_sx    <= h_q;
      o_sy    <= v_q;
      o_frame <= frame_c;
      hs_r    <= hs_c;
      vs_r    <= vs_c;
    end
  end

  // Syncs share the de delay so their edges keep the same offset to o_req.
  dvi_delay_line #(
    .DEPTH(PIX_LAT),
    .WIDTH(3)
  ) u_align (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .din    ({o_req, hs_r, vs_r}),
    .dout   ({de_d, hs_d, vs_d})
  );

  assign o_de    = de_d;
  assign o_ctrl0 = {sync_level(vs_d, V_POL), sync_level(hs_d, H_POL)};
  assign o_ctrl1 = CTRL_IDLE;
  assign o_ctrl2 = CTRL_IDLE;
  assign o_busy  = running;

endmodule
